// File: rtl/display_pkg.sv
// Shared constants and FSM state type for the frame writer and its pixel packer.
package display_pkg;
  localparam int unsigned FRAME_LAST_ADDR = 307192;
  localparam int unsigned ADDR_STEP       = 8;
  localparam int unsigned PIX_PER_WORD    = 8;
  localparam int unsigned LANE_W          = 32;
  localparam int unsigned ADDR_W          = 19;
  localparam int unsigned IDX_W           = 3;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } fw_state_e;
endpackage

// File: rtl/frame_writer_if.sv
// Pixel stream in, 256-bit write requests out to the memory arbiter.
interface frame_writer_if;
  logic [23:0]  pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         frame_sync;
  logic [255:0] data_wr;
  logic [255:0] data_rd;
  logic [27:0]  mem_data_addr;
  logic         mem_rw_data;
  logic         mem_valid_data;
  logic         mem_ready_data;
  logic         last_addr_update;

  modport master (
    input  pix_data, pix_valid, frame_sync, data_rd, mem_ready_data,
    output pix_ready, data_wr, mem_data_addr, mem_rw_data, mem_valid_data,
           last_addr_update
  );

  modport slave (
    output pix_data, pix_valid, frame_sync, data_rd, mem_ready_data,
    input  pix_ready, data_wr, mem_data_addr, mem_rw_data, mem_valid_data,
           last_addr_update
  );
endinterface

// File: rtl/pixel_packer.sv
// Writes one pixel per enabled cycle into lane idx of the 256-bit word.
// Define FRAME_WRITER_GRAY_EN to store {Y,Y,Y} with Y=(R+2G+B)>>2 instead of RGB.
module pixel_packer
  import display_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [IDX_W-1:0]                       idx,
  input  logic [23:0]                            pix,
  output logic [PIX_PER_WORD-1:0][LANE_W-1:0]    word
);
  logic [PIX_PER_WORD-1:0][LANE_W-1:0] word_q, word_d;
  logic [23:0]                         lane_px;

`ifdef FRAME_WRITER_GRAY_EN
  logic [9:0] lum_sum;
  always_comb begin
    lum_sum = {2'b00, pix[23:16]} + {1'b0, pix[15:8], 1'b0} + {2'b00, pix[7:0]};
    lane_px = {3{lum_sum[9:2]}};
  end
`else
  always_comb lane_px = pix;
`endif

  always_comb begin
    word_d = word_q;
    if (wr_en) word_d[idx] = {8'h00, lane_px};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word_q <= '0;
    else      word_q <= word_d;
  end

  assign word = word_q;
endmodule

// File: rtl/frame_writer.sv
// Packs 8 pixels per 256-bit word and issues sequential frame-buffer writes.
// Optional FRAME_WRITER_GRAY_EN (handled in pixel_packer) stores grayscale.
module frame_writer
  import display_pkg::*;
#(
  parameter int unsigned LAST_ADDR = FRAME_LAST_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  frame_writer_if.master  bus
);
  fw_state_e         state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              last_q, last_d;
  logic              rdy_q, rdy_d;
  logic              pix_ready, acc, wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [PIX_PER_WORD-1:0][LANE_W-1:0] word;
  logic              unused_rd;

  assign pix_ready = rdy_q && (state_q == FILL);
  assign acc       = bus.pix_valid && pix_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    last_d  = 1'b0;
    rdy_d   = 1'b1;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    case (state_q)
      FILL: begin
        if (bus.frame_sync) begin
          // Realign: the pixel of this cycle (if any) becomes lane 0 at address 0.
          addr_d = '0;
          cnt_d  = '0;
          if (acc) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            cnt_d  = IDX_W'(1);
          end
        end else if (acc) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(PIX_PER_WORD - 1)) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready_data) begin
          state_d = FILL;
          cnt_d   = '0;
          pend_d  = 1'b0;
          if (addr_q == ADDR_W'(LAST_ADDR)) begin
            addr_d = '0;
            last_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
          end
          // A realign seen during the write takes effect once it completes.
          if (pend_q || bus.frame_sync) addr_d = '0;
        end else if (bus.frame_sync) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
    end
  end

  pixel_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .idx   (wr_idx),
    .pix   (bus.pix_data),
    .word  (word)
  );

  assign unused_rd            = ^bus.data_rd;
  assign bus.pix_ready        = pix_ready;
  assign bus.data_wr          = word;
  assign bus.mem_data_addr    = {9'b0, addr_q};
  assign bus.mem_rw_data      = 1'b1;
  assign bus.mem_valid_data   = (state_q == ISSUE);
  assign bus.last_addr_update = last_q;
endmodule

// File: tb/tb_frame_writer.sv
// Randomized scoreboard bench for frame_writer; a short frame length keeps the
// wrap scenario within a bounded cycle count.
module tb_frame_writer;
  import display_pkg::*;

  localparam int unsigned TB_LAST = 192;

  typedef struct {
    logic [27:0]  addr;
    logic [255:0] data;
    bit           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_writer_if bus();

  frame_writer #(.LAST_ADDR(TB_LAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] lanes[$];
  int          m_addr = 0;
  bit          busy = 0, pend = 0, lat_chk = 0;
  int          total = 0, bad = 0;
  int          n_last = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_lane(input logic [23:0] p);
`ifdef FRAME_WRITER_GRAY_EN
    int y;
    y = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    return {8'h00, y[7:0], y[7:0], y[7:0]};
`else
    return {8'h00, p};
`endif
  endfunction

  function automatic logic [255:0] ref_word();
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = lanes[k];
    return w;
  endfunction

  // Monitor: pops the scoreboard on every accepted write request.
  bit           hold_v = 0, chk_last = 0;
  logic [255:0] hold_d;
  logic [27:0]  hold_a;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v   = 0;
      chk_last = 0;
    end else begin
      bit nl;
      exp_t e;
      nl = 0;
      if (bus.last_addr_update) n_last++;
      if (chk_last || bus.last_addr_update) check("last_pulse", bus.last_addr_update, chk_last);
      if (hold_v && bus.mem_valid_data) begin
        check("hold_data", bus.data_wr, hold_d);
        check("hold_addr", bus.mem_data_addr, hold_a);
        check("hold_pix_ready", bus.pix_ready, 0);
      end
      hold_v = bus.mem_valid_data && !bus.mem_ready_data;
      hold_d = bus.data_wr;
      hold_a = bus.mem_data_addr;
      if (bus.mem_valid_data && bus.mem_ready_data) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write addr=%h", bus.mem_data_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", bus.data_wr, e.data);
          check("wr_addr", bus.mem_data_addr, e.addr);
          check("wr_rw", bus.mem_rw_data, 1);
          nl = e.last;
        end
      end
      chk_last = nl;
    end
  end

  // One clock of stimulus; the reference model advances from what was
  // exchanged at this edge.
  task automatic cycle(output bit acc);
    bit fs, hs;
    logic [23:0] pd;
    @(negedge clk);
    if (lat_chk) begin
      check("valid_latency", bus.mem_valid_data, 1);
      lat_chk = 0;
    end
    acc = bus.pix_valid && bus.pix_ready;
    fs  = bus.frame_sync;
    hs  = bus.mem_valid_data && bus.mem_ready_data;
    pd  = bus.pix_data;
    @(posedge clk); #1;
    if (hs) begin
      busy   = 0;
      m_addr = pend ? 0 : ((m_addr == TB_LAST) ? 0 : m_addr + 8);
      pend   = 0;
    end
    if (fs) begin
      if (busy) pend = 1;
      else begin
        lanes.delete();
        m_addr = 0;
      end
    end
    if (acc) begin
      lanes.push_back(ref_lane(pd));
      if (lanes.size() == 8) begin
        exp_q.push_back('{addr: 28'(m_addr), data: ref_word(), last: (m_addr == TB_LAST)});
        lanes.delete();
        busy    = 1;
        lat_chk = 1;
      end
    end
  endtask

  task automatic tick(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  task automatic send_pix(input logic [23:0] p);
    bit a;
    int t;
    a = 0;
    bus.pix_valid = 1;
    bus.pix_data  = p;
    for (t = 0; t < 50 && !a; t++) cycle(a);
    if (!a) begin
      total++; bad++;
      $display("FAIL pix_accept_timeout act=0 exp=1");
    end
    bus.pix_valid = 0;
  endtask

  task automatic send_word();
    for (int k = 0; k < 8; k++) send_pix(24'($urandom));
  endtask

  task automatic wait_idle();
    bus.pix_valid = 0;
    for (int t = 0; t < 50 && busy; t++) tick(1);
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout act=busy exp=idle");
    end
  endtask

  task automatic do_reset();
    rst = 0;
    bus.pix_valid = 0;
    bus.frame_sync = 0;
    bus.mem_ready_data = 0;
    exp_q.delete();
    lanes.delete();
    m_addr = 0; busy = 0; pend = 0; lat_chk = 0;
    #1;
    check("rst_valid", bus.mem_valid_data, 0);
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_last", bus.last_addr_update, 0);
    check("rst_addr", bus.mem_data_addr, 0);
    check("rst_data", bus.data_wr, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("post_rst_pix_ready", bus.pix_ready, 1);
  endtask

  initial begin
    bus.pix_data = '0;
    bus.pix_valid = 0;
    bus.frame_sync = 0;
    bus.mem_ready_data = 0;
    bus.data_rd = {8{$urandom}};
    #2;
    do_reset();

    // Counting pixels into one word with the arbiter always ready.
    bus.mem_ready_data = 1;
    for (int k = 1; k <= 8; k++) send_pix(24'(k));
    wait_idle();

    // Arbiter stalls for several cycles while a word is pending.
    bus.mem_ready_data = 0;
    send_word();
    tick(5);
    bus.mem_ready_data = 1;
    wait_idle();

    // Partial word discarded by realign, then a word including the gray sample.
    for (int k = 0; k < 3; k++) send_pix(24'($urandom));
    bus.frame_sync = 1; tick(1); bus.frame_sync = 0;
    send_pix(24'h4080C0);
    for (int k = 0; k < 7; k++) send_pix(24'($urandom));
    wait_idle();

    // Realign while the word at address 80 is waiting.
    do_reset();
    bus.mem_ready_data = 1;
    for (int w = 0; w < 10; w++) send_word();
    wait_idle();
    bus.mem_ready_data = 0;
    send_word();
    tick(1);
    bus.frame_sync = 1; tick(1); bus.frame_sync = 0;
    tick(2);
    bus.mem_ready_data = 1;
    wait_idle();
    send_word();
    wait_idle();

    // Whole frame: wrap after the last address with a single pulse.
    do_reset();
    n_last = 0;
    bus.mem_ready_data = 1;
    for (int w = 0; w < int'(TB_LAST / 8) + 2; w++) send_word();
    wait_idle();
    tick(2);
    check("last_count", n_last, 1);

    // Random traffic with occasional realigns.
    for (int i = 0; i < 2500; i++) begin
      bus.pix_valid      = ($urandom_range(9) < 7);
      bus.pix_data       = 24'($urandom);
      bus.mem_ready_data = $urandom_range(1);
      bus.frame_sync     = ($urandom_range(59) == 0) && !(busy && bus.mem_ready_data);
      tick(1);
    end
    bus.frame_sync = 0;
    bus.mem_ready_data = 1;
    wait_idle();

    // Reset while a request is outstanding drops it with no further write.
    bus.mem_ready_data = 0;
    send_word();
    tick(1);
    check("issue_before_rst", bus.mem_valid_data, 1);
    do_reset();
    bus.mem_ready_data = 1;
    tick(20);

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick(1);
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
